// File: rtl/urv_dmem_wb_master.sv
// Data-memory request target: runs each core load/store as one Wishbone pipelined transfer.
// Latency: request-to-ready is at least 2 cycles (ack in the first strobe cycle), longer under stall/wait.
// Backpressure: dm_ready_o is low for the whole transfer; wb_stall_i holds the strobe in ISSUE.
module urv_dmem_wb_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  // Counter is at least 8 bits and grows if a longer timeout is configured.
  localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             accept;
  logic             resp_ok;
  logic             ack_hit;
  logic             err_hit;
  logic             tmo_hit;
  logic             ready_q;

  // A response only counts once our strobe has been taken (not while stalled in ISSUE).
  assign resp_ok = (state == S_WAIT) || ((state == S_ISSUE) && !wb_stall_i);
  // err dominates when the slave raises ack and err together.
  assign err_hit = resp_ok && wb_err_i;
  assign ack_hit = resp_ok && wb_ack_i && !wb_err_i;
  // Timeout fires on the last allowed edge unless a real response arrives on it.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) &&
                   (tmo_cnt == TMO_LAST) && !ack_hit && !err_hit;

  assign wb_cyc_o   = (state != S_IDLE);
  assign wb_stb_o   = (state == S_ISSUE);
  assign dm_ready_o = ready_q;

  // Next-state decode: accept in IDLE, hold strobe under stall, finish on ack/err/timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_hit || err_hit || tmo_hit) begin
          state_nxt = S_IDLE;
        end else if (!wb_stall_i) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_hit || err_hit || tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request latches, timeout counter, load data and completion pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      ready_q         <= 1'b1;
      wb_we_o         <= 1'b0;
      wb_adr_o        <= 32'h0;
      wb_sel_o        <= 4'h0;
      wb_dat_o        <= 32'h0;
      dm_data_l_o     <= 32'h0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_bus_error_o  <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      state           <= state_nxt;
      ready_q         <= (state_nxt == S_IDLE);
      dm_load_done_o  <= ack_hit && !wb_we_o;
      dm_store_done_o <= ack_hit && wb_we_o;
      dm_bus_error_o  <= err_hit || tmo_hit;
      if (accept) begin
        wb_we_o  <= dm_store_i;
        wb_adr_o <= {dm_addr_i[31:2], 2'b00};
        wb_sel_o <= dm_data_select_i;
        wb_dat_o <= dm_data_s_i;
        tmo_cnt  <= '0;
      end else if (state != S_IDLE) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (ack_hit && !wb_we_o) begin
        dm_data_l_o <= wb_dat_i;
      end
    end
  end

endmodule
